regfile_bypass_sb: RTL and testbench

- Parametrised successor to the fixed 32x32, 2-read-port register file.
- Single encoded write port replaces the 32-bit one-hot enable bus.
- Read-port count is configurable; write-to-read bypass is optional; x0 is hardwired to zero.
- Adds a busy scoreboard so the pipeline controller can detect load-use and multicycle hazards. Sits in decode, feeding operand muxes and the hazard unit.

---
 rtl/regfile_bypass_sb_pkg.sv | 19 +
 rtl/regfile_bypass_sb_if.sv | 33 +++
 rtl/regfile_bypass_sb_scoreboard.sv | 40 ++++
 rtl/regfile_bypass_sb.sv | 77 +++++++
 tb/tb_regfile_bypass_sb.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_bypass_sb_pkg.sv
// rtl/regfile_bypass_sb_pkg.sv - shared constants and packed-bus field helper
package rf_pkg;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int ZERO_ADDR      = 0;
   localparam int BUS_MAX        = 256;
   localparam int FIELD_MAX      = 64;

   // Field idx of a zero-extended packed bus; width must not exceed FIELD_MAX.
   function automatic logic [FIELD_MAX-1:0] get_field(input logic [BUS_MAX-1:0] bus,
                                                      input int idx, input int width);
      logic [FIELD_MAX-1:0] r;
      r = '0;
      for (int b = 0; b < FIELD_MAX; b++) begin
         if (b < width) r[b] = bus[8'(idx * width + b)];
      end
      return r;
   endfunction
endpackage

// File: rtl/regfile_bypass_sb_if.sv
// rtl/regfile_bypass_sb_if.sv - write, read, mark and scoreboard bus of the register file
interface regfile_bypass_sb_if
   import rf_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_READ   = 2
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic                           write_enable;
   logic [ADDR_WIDTH-1:0]          write_address;
   logic [DATA_WIDTH-1:0]          write_data;
   logic [NUM_READ*ADDR_WIDTH-1:0] read_address;
   logic [NUM_READ*DATA_WIDTH-1:0] read_data;
   logic [NUM_READ-1:0]            read_busy;
   logic                           mark_valid;
   logic [ADDR_WIDTH-1:0]          mark_address;
   logic                           flush;
   logic [DEPTH-1:0]               busy_vector;

   modport master (
      output write_enable, write_address, write_data, read_address,
             mark_valid, mark_address, flush,
      input  read_data, read_busy, busy_vector
   );

   modport slave (
      input  write_enable, write_address, write_data, read_address,
             mark_valid, mark_address, flush,
      output read_data, read_busy, busy_vector
   );
endinterface

// File: rtl/regfile_bypass_sb_scoreboard.sv
// rtl/regfile_bypass_sb_scoreboard.sv - per-register busy flags: flush > mark > write-clear > hold
module regfile_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int ZERO_REG   = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       mark_valid,
   input  logic [ADDR_WIDTH-1:0]      mark_address,
   input  logic                       write_enable,
   input  logic [ADDR_WIDTH-1:0]      write_address,
   input  logic                       flush,
   output logic [(1<<ADDR_WIDTH)-1:0] busy_vector
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DEPTH-1:0] busy, busy_next;

   always_comb begin
      busy_next = busy;
      for (int n = 0; n < DEPTH; n++) begin
         if (flush)
            busy_next[n] = 1'b0;
         else if (mark_valid && mark_address == ADDR_WIDTH'(n))
            busy_next[n] = 1'b1;
         else if (write_enable && write_address == ADDR_WIDTH'(n))
            busy_next[n] = 1'b0;
      end
      if (ZERO_REG != 0) busy_next[ZERO_ADDR] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) busy <= '0;
      else        busy <= busy_next;
   end

   assign busy_vector = busy;
endmodule

// File: rtl/regfile_bypass_sb.sv
// rtl/regfile_bypass_sb.sv - multi-port register file with optional write bypass and busy scoreboard
module regfile_bypass_sb
   import rf_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_READ   = 2,
   parameter int BYPASS     = 1,
   parameter int ZERO_REG   = 1
) (
   input logic                clk,
   input logic                reset,
   regfile_bypass_sb_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0]          mem [DEPTH];
   logic [DEPTH-1:0]               busy;
   logic                           write_ok;
   logic [BUS_MAX-1:0]             ra_ext;
   logic [NUM_READ*DATA_WIDTH-1:0] rd;
   logic [NUM_READ-1:0]            rb;

   assign ra_ext = BUS_MAX'(bus.read_address);

   always_comb begin
      write_ok = bus.write_enable &&
                 !((ZERO_REG != 0) && (bus.write_address == ADDR_WIDTH'(ZERO_ADDR)));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int n = 0; n < DEPTH; n++) mem[n] <= '0;
      end else if (write_ok) begin
         mem[bus.write_address] <= bus.write_data;
      end
   end

   regfile_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
   ) u_scoreboard (
      .clk           (clk),
      .reset         (reset),
      .mark_valid    (bus.mark_valid),
      .mark_address  (bus.mark_address),
      .write_enable  (bus.write_enable),
      .write_address (bus.write_address),
      .flush         (bus.flush),
      .busy_vector   (busy)
   );

   // A bypass hit also hides the busy flag: the consumer gets the value this cycle.
   always_comb begin
      rd = '0;
      rb = '0;
      for (int i = 0; i < NUM_READ; i++) begin
         logic [ADDR_WIDTH-1:0] addr;
         logic                  zero_hit;
         logic                  hit;
         addr     = ADDR_WIDTH'(get_field(ra_ext, i, ADDR_WIDTH));
         zero_hit = (ZERO_REG != 0) && (addr == ADDR_WIDTH'(ZERO_ADDR));
         hit      = (BYPASS != 0) && write_ok && (bus.write_address == addr);
         if (zero_hit)
            rd[i*DATA_WIDTH +: DATA_WIDTH] = '0;
         else if (hit)
            rd[i*DATA_WIDTH +: DATA_WIDTH] = bus.write_data;
         else
            rd[i*DATA_WIDTH +: DATA_WIDTH] = mem[addr];
         rb[i] = busy[addr] && !hit;
      end
   end

   assign bus.read_data   = rd;
   assign bus.read_busy   = rb;
   assign bus.busy_vector = busy;
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// tb/tb_regfile_bypass_sb.sv - directed checks on bypass, zero-register, three-port and no-bypass builds
module tb_regfile_bypass_sb;
   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   regfile_bypass_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) ifa ();
   regfile_bypass_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) ifb ();
   regfile_bypass_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_READ(3)) ifc ();

   regfile_bypass_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .BYPASS(1), .ZERO_REG(1))
      dut_a (.clk(clk), .reset(rst_n), .bus(ifa));
   regfile_bypass_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .BYPASS(0), .ZERO_REG(1))
      dut_b (.clk(clk), .reset(rst_n), .bus(ifb));
   regfile_bypass_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_READ(3), .BYPASS(1), .ZERO_REG(1))
      dut_c (.clk(clk), .reset(rst_n), .bus(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ifa.write_enable = 0; ifa.write_address = '0; ifa.write_data = '0; ifa.read_address = '0;
      ifa.mark_valid = 0; ifa.mark_address = '0; ifa.flush = 0;
      ifb.write_enable = 0; ifb.write_address = '0; ifb.write_data = '0; ifb.read_address = '0;
      ifb.mark_valid = 0; ifb.mark_address = '0; ifb.flush = 0;
      ifc.write_enable = 0; ifc.write_address = '0; ifc.write_data = '0; ifc.read_address = '0;
      ifc.mark_valid = 0; ifc.mark_address = '0; ifc.flush = 0;
   endtask

   task automatic test_reset();
      ifa.write_enable = 1; ifa.write_address = 5'd5; ifa.write_data = 32'h0000_0055;
      ifa.mark_valid = 1; ifa.mark_address = 5'd9;
      tick();
      idle();
      ifa.read_address = {5'd9, 5'd5};
      #1;
      vectors++;
      if (ifa.read_data[31:0] !== 32'h0000_0055) begin
         miscompares++;
         $display("FAIL pre_reset_rd0: got %h expected %h", ifa.read_data[31:0], 32'h55);
      end
      #2 rst_n = 0;
      #1;
      vectors++;
      if (ifa.read_data !== 64'h0 || ifa.busy_vector !== 32'h0 || ifa.read_busy !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_low: rd %h bv %h rb %b expected all zero",
                  ifa.read_data, ifa.busy_vector, ifa.read_busy);
      end
      tick();
      rst_n = 1;
      tick();
      vectors++;
      if (ifa.read_data !== 64'h0 || ifa.busy_vector !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_release: rd %h bv %h expected zero", ifa.read_data, ifa.busy_vector);
      end
   endtask

   task automatic test_write_read();
      ifa.write_enable = 1; ifa.write_address = 5'd5; ifa.write_data = 32'hDEAD_BEEF;
      tick();
      idle();
      ifa.read_address = {5'd0, 5'd5};
      #1;
      vectors++;
      if (ifa.read_data[31:0] !== 32'hDEAD_BEEF || ifa.read_data[63:32] !== 32'h0) begin
         miscompares++;
         $display("FAIL write_read: got %h expected %h", ifa.read_data, 64'h0000_0000_DEAD_BEEF);
      end
      ifa.write_enable = 1; ifa.write_address = 5'd0; ifa.write_data = 32'h0000_1234;
      #1;
      vectors++;
      if (ifa.read_data[63:32] !== 32'h0) begin
         miscompares++;
         $display("FAIL x0_bypass: got %h expected 0", ifa.read_data[63:32]);
      end
      tick();
      ifa.write_enable = 0;
      #1;
      vectors++;
      if (ifa.read_data[63:32] !== 32'h0) begin
         miscompares++;
         $display("FAIL x0_stored: got %h expected 0", ifa.read_data[63:32]);
      end
      idle();
   endtask

   task automatic test_bypass();
      ifa.write_enable = 1; ifa.write_address = 5'd7; ifa.write_data = 32'h11;
      ifb.write_enable = 1; ifb.write_address = 5'd7; ifb.write_data = 32'h11;
      tick();
      ifa.write_data = 32'hA5A5_A5A5; ifa.read_address = {5'd7, 5'd7};
      ifb.write_data = 32'hA5A5_A5A5; ifb.read_address = {5'd7, 5'd7};
      #1;
      vectors++;
      if (ifa.read_data !== 64'hA5A5_A5A5_A5A5_A5A5) begin
         miscompares++;
         $display("FAIL bypass_on: got %h expected %h", ifa.read_data, 64'hA5A5_A5A5_A5A5_A5A5);
      end
      vectors++;
      if (ifb.read_data !== 64'h0000_0011_0000_0011) begin
         miscompares++;
         $display("FAIL bypass_off_same: got %h expected %h", ifb.read_data, 64'h0000_0011_0000_0011);
      end
      tick();
      ifa.write_enable = 0; ifb.write_enable = 0;
      #1;
      vectors++;
      if (ifb.read_data !== 64'hA5A5_A5A5_A5A5_A5A5) begin
         miscompares++;
         $display("FAIL bypass_off_next: got %h expected %h", ifb.read_data, 64'hA5A5_A5A5_A5A5_A5A5);
      end
      idle();
   endtask

   task automatic test_scoreboard();
      ifa.mark_valid = 1; ifa.mark_address = 5'd9;
      ifb.mark_valid = 1; ifb.mark_address = 5'd9;
      tick();
      idle();
      ifa.read_address = {5'd0, 5'd9};
      ifb.read_address = {5'd0, 5'd9};
      #1;
      vectors++;
      if (ifa.busy_vector[9] !== 1'b1 || ifa.read_busy[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL mark_busy: bv9 %b rb0 %b expected 1 1", ifa.busy_vector[9], ifa.read_busy[0]);
      end
      ifa.write_enable = 1; ifa.write_address = 5'd9; ifa.write_data = 32'hCAFE_0009;
      ifb.write_enable = 1; ifb.write_address = 5'd9; ifb.write_data = 32'hCAFE_0009;
      #1;
      vectors++;
      if (ifa.read_busy[0] !== 1'b0 || ifa.read_data[31:0] !== 32'hCAFE_0009 || ifa.busy_vector[9] !== 1'b1) begin
         miscompares++;
         $display("FAIL wb_bypass_busy: rb0 %b rd0 %h bv9 %b expected 0 cafe0009 1",
                  ifa.read_busy[0], ifa.read_data[31:0], ifa.busy_vector[9]);
      end
      vectors++;
      if (ifb.read_busy[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL wb_nobypass_busy: got %b expected 1", ifb.read_busy[0]);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (ifa.busy_vector[9] !== 1'b0 || ifb.busy_vector[9] !== 1'b0) begin
         miscompares++;
         $display("FAIL wb_clear: a %b b %b expected 0 0", ifa.busy_vector[9], ifb.busy_vector[9]);
      end
   endtask

   task automatic test_mark_write_flush();
      ifa.mark_valid = 1; ifa.mark_address = 5'd3;
      ifa.write_enable = 1; ifa.write_address = 5'd3; ifa.write_data = 32'h77;
      tick();
      idle();
      ifa.read_address = {5'd0, 5'd3};
      #1;
      vectors++;
      if (ifa.busy_vector[3] !== 1'b1 || ifa.read_data[31:0] !== 32'h77 || ifa.read_busy[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL mark_over_write: bv3 %b rd0 %h rb0 %b expected 1 77 1",
                  ifa.busy_vector[3], ifa.read_data[31:0], ifa.read_busy[0]);
      end
      ifa.mark_valid = 1; ifa.mark_address = 5'd4;
      tick();
      ifa.mark_address = 5'd6;
      tick();
      ifa.mark_address = 5'd0;
      tick();
      ifa.mark_valid = 0;
      #1;
      vectors++;
      if (ifa.busy_vector !== 32'h0000_0058) begin
         miscompares++;
         $display("FAIL multi_mark: got %h expected %h", ifa.busy_vector, 32'h58);
      end
      ifa.flush = 1; ifa.mark_valid = 1; ifa.mark_address = 5'd8;
      ifa.write_enable = 1; ifa.write_address = 5'd10; ifa.write_data = 32'hAB;
      tick();
      idle();
      ifa.read_address = {5'd0, 5'd10};
      #1;
      vectors++;
      if (ifa.busy_vector !== 32'h0 || ifa.read_data[31:0] !== 32'hAB) begin
         miscompares++;
         $display("FAIL flush: bv %h rd0 %h expected 0 ab", ifa.busy_vector, ifa.read_data[31:0]);
      end
      idle();
   endtask

   task automatic test_three_port();
      ifc.write_enable = 1;
      ifc.write_address = 4'd1;  ifc.write_data = 32'd1;  tick();
      ifc.write_address = 4'd2;  ifc.write_data = 32'd2;  tick();
      ifc.write_address = 4'd15; ifc.write_data = 32'd15; tick();
      idle();
      ifc.read_address = {4'd15, 4'd2, 4'd1};
      #1;
      vectors++;
      if (ifc.read_data !== {32'd15, 32'd2, 32'd1}) begin
         miscompares++;
         $display("FAIL three_port: got %h expected %h", ifc.read_data, {32'd15, 32'd2, 32'd1});
      end
      ifc.mark_valid = 1; ifc.mark_address = 4'd15;
      tick();
      ifc.mark_valid = 0;
      #1;
      vectors++;
      if (ifc.busy_vector !== 16'h8000 || ifc.read_busy !== 3'b100) begin
         miscompares++;
         $display("FAIL three_port_mark: bv %h rb %b expected 8000 100", ifc.busy_vector, ifc.read_busy);
      end
      #2 rst_n = 0;
      #1;
      vectors++;
      if (ifc.busy_vector !== 16'h0 || ifc.read_data !== 96'h0 || ifc.read_busy !== 3'b000) begin
         miscompares++;
         $display("FAIL async_reset: bv %h rd %h rb %b expected zero",
                  ifc.busy_vector, ifc.read_data, ifc.read_busy);
      end
      tick();
      rst_n = 1;
      tick();
      vectors++;
      if (ifc.busy_vector !== 16'h0 || ifc.read_data !== 96'h0) begin
         miscompares++;
         $display("FAIL async_reset_release: bv %h rd %h expected zero", ifc.busy_vector, ifc.read_data);
      end
      idle();
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 0;
      idle();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      test_reset();
      test_write_read();
      test_bypass();
      test_scoreboard();
      test_mark_write_flush();
      test_three_port();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
